pc_sequencer: RTL and testbench

- Control FSM that sequences the program counter register through fetch, decode and execute.
- Issues a fetch request to instruction memory and waits for the memory acknowledge.
- Latches the returned opcode and target, then computes the next PC (increment, jump, conditional branch, call/return, halt).
- Drives the PC register's data input and synchronous load enable; reads back its current value.

---
 rtl/pc_sequencer.sv | 255 +++++++++++++++++++++++++
 tb/tb_pc_sequencer.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//   Control FSM that steps the program counter register through
//   FETCH -> DECODE -> EXEC. It requests an instruction, latches the returned
//   opcode/target, computes the next PC and pulses the PC register load.
//
//   Optional build macro: SEQ_STACK_EN
//     defined   : return-address stack of STACK_DEPTH entries for CALL/RET,
//                 with a sticky over/underflow flag on STK_ERR.
//     undefined : CALL behaves as JMP, RET as NOP, STK_ERR tied low.
//
// Ports
//   CLK        in   clock, rising edge
//   RESET      in   asynchronous, active-high reset
//   START      in   begin/resume execution from IDLE or HALT
//   PC_CUR     in   current PC register value             [ADDR_W]
//   MEM_ACK    in   instruction memory data valid
//   OPCODE     in   instruction opcode                     [3]
//   TARGET     in   jump/branch/call target                [ADDR_W]
//   ZERO       in   datapath zero flag (sampled in DECODE)
//   FETCH_REQ  out  fetch request, held until MEM_ACK
//   IR_LOAD    out  instruction register capture strobe (FETCH && MEM_ACK)
//   PC_NEXT    out  next PC, drives the PC register data input [ADDR_W]
//   PC_LOAD    out  one-cycle PC register load enable (EXEC)
//   HALTED     out  high in HALT
//   STK_ERR    out  sticky stack over/underflow flag
// ---------------------------------------------------------------------------
module pc_sequencer #(
  parameter int unsigned ADDR_W      = 2,
  parameter int unsigned STACK_DEPTH = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic [ADDR_W-1:0] PC_CUR,
  input  logic              MEM_ACK,
  input  logic [2:0]        OPCODE,
  input  logic [ADDR_W-1:0] TARGET,
  input  logic              ZERO,
  output logic              FETCH_REQ,
  output logic              IR_LOAD,
  output logic [ADDR_W-1:0] PC_NEXT,
  output logic              PC_LOAD,
  output logic              HALTED,
  output logic              STK_ERR
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_JMP  = 3'b001;
  localparam logic [2:0] OP_BRZ  = 3'b010;
  localparam logic [2:0] OP_BRNZ = 3'b011;
  localparam logic [2:0] OP_CALL = 3'b100;
  localparam logic [2:0] OP_RET  = 3'b101;
  localparam logic [2:0] OP_HLT  = 3'b110;

  state_t              r_state;
  state_t              w_next_state;
  logic                w_fetch_req_d;
  logic                w_pc_load_d;
  logic                w_halted_d;

  logic                r_fetch_req;
  logic                r_pc_load;
  logic                r_halted;
  logic [2:0]          r_opcode;
  logic [ADDR_W-1:0]   r_target;
  logic [ADDR_W-1:0]   r_pc_next;

  logic                w_ir_load;
  logic                w_in_decode;
  logic [ADDR_W-1:0]   w_pc_inc;
  logic [ADDR_W-1:0]   w_pc_calc;
  logic [ADDR_W-1:0]   w_ret_pc;

  // Instruction capture happens in the cycle memory acknowledges the fetch.
  assign w_ir_load   = (r_state == S_FETCH) && MEM_ACK;
  assign w_in_decode = (r_state == S_DECODE);

  // Sequential increment wraps naturally at ADDR_W bits.
  assign w_pc_inc    = PC_CUR + ADDR_W'(1);

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode plus next values of the registered Moore outputs.
  always_comb begin
    w_next_state  = r_state;
    w_fetch_req_d = 1'b0;
    w_pc_load_d   = 1'b0;
    w_halted_d    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (START) begin
          w_next_state = S_FETCH;
        end
      end
      S_FETCH: begin
        if (MEM_ACK) begin
          w_next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        w_next_state = S_EXEC;
      end
      S_EXEC: begin
        w_next_state = (r_opcode == OP_HLT) ? S_HALT : S_FETCH;
      end
      S_HALT: begin
        if (START) begin
          w_next_state = S_FETCH;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase

    // Outputs are registered from the state being entered, so they line up
    // exactly with the state register and clear with it on RESET.
    w_fetch_req_d = (w_next_state == S_FETCH);
    w_pc_load_d   = (w_next_state == S_EXEC);
    w_halted_d    = (w_next_state == S_HALT);
  end

  // Registered control outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_fetch_req <= 1'b0;
      r_pc_load   <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      r_fetch_req <= w_fetch_req_d;
      r_pc_load   <= w_pc_load_d;
      r_halted    <= w_halted_d;
    end
  end

  // Instruction latch: opcode and target captured on the acknowledge cycle.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_opcode <= 3'b000;
      r_target <= '0;
    end else if (w_ir_load) begin
      r_opcode <= OPCODE;
      r_target <= TARGET;
    end
  end

  // Next-PC selection from the latched instruction; ZERO is live in DECODE.
  always_comb begin
    w_pc_calc = w_pc_inc;
    case (r_opcode)
      OP_NOP, OP_HLT:  w_pc_calc = w_pc_inc;
      OP_JMP, OP_CALL: w_pc_calc = r_target;
      OP_BRZ:          w_pc_calc = ZERO ? r_target : w_pc_inc;
      OP_BRNZ:         w_pc_calc = ZERO ? w_pc_inc : r_target;
      OP_RET:          w_pc_calc = w_ret_pc;
      default:         w_pc_calc = w_pc_inc;
    endcase
  end

  // PC_NEXT is updated only in DECODE and holds through EXEC and beyond.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_pc_next <= '0;
    end else if (w_in_decode) begin
      r_pc_next <= w_pc_calc;
    end
  end

`ifdef SEQ_STACK_EN
  // Pointer counts 0..STACK_DEPTH; storage is rounded up to a power of two
  // so the entry index never needs more bits than the array provides.
  localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int unsigned STK_N = 1 << IDX_W;

  logic [ADDR_W-1:0] r_stack [STK_N];
  logic [SP_W-1:0]   r_sp;
  logic              r_stk_err;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_stk_fault;
  logic [IDX_W-1:0]  w_top_idx;
  logic [IDX_W-1:0]  w_push_idx;

  assign w_full      = (r_sp == SP_W'(STACK_DEPTH));
  assign w_empty     = (r_sp == '0);
  assign w_top_idx   = IDX_W'(r_sp - SP_W'(1));
  assign w_push_idx  = IDX_W'(r_sp);
  assign w_push      = w_in_decode && (r_opcode == OP_CALL) && !w_full;
  assign w_pop       = w_in_decode && (r_opcode == OP_RET)  && !w_empty;
  assign w_stk_fault = w_in_decode &&
                       (((r_opcode == OP_CALL) && w_full) ||
                        ((r_opcode == OP_RET)  && w_empty));

  // An empty-stack RET falls through to the next sequential address.
  assign w_ret_pc = w_empty ? w_pc_inc : r_stack[w_top_idx];

  // Return-address stack and sticky error flag.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_sp      <= '0;
      r_stk_err <= 1'b0;
      for (int unsigned i = 0; i < STK_N; i++) begin
        r_stack[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_stack[w_push_idx] <= w_pc_inc;
        r_sp                <= r_sp + SP_W'(1);
      end else if (w_pop) begin
        r_sp <= r_sp - SP_W'(1);
      end
      if (w_stk_fault) begin
        r_stk_err <= 1'b1;
      end
    end
  end

  assign STK_ERR = r_stk_err;
`else
  // Without the stack, RET degenerates to a sequential step.
  logic w_unused_depth;

  assign w_ret_pc       = w_pc_inc;
  assign STK_ERR        = 1'b0;
  // Stack depth only matters when the return stack is built.
  assign w_unused_depth = ^STACK_DEPTH;
`endif

  assign FETCH_REQ = r_fetch_req;
  assign IR_LOAD   = w_ir_load;
  assign PC_NEXT   = r_pc_next;
  assign PC_LOAD   = r_pc_load;
  assign HALTED    = r_halted;

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
//   Bench for pc_sequencer: models the PC register and a 4-word instruction
//   memory with programmable acknowledge delay. Expected PC_NEXT values are
//   queued when a program is started and popped on every PC_LOAD.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

  localparam int unsigned ADDR_W = 2;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_JMP  = 3'b001;
  localparam logic [2:0] OP_BRZ  = 3'b010;
  localparam logic [2:0] OP_BRNZ = 3'b011;
  localparam logic [2:0] OP_CALL = 3'b100;
  localparam logic [2:0] OP_RET  = 3'b101;
  localparam logic [2:0] OP_HLT  = 3'b110;
  localparam logic [2:0] OP_RSV  = 3'b111;

  logic              CLK = 1'b0;
  logic              RESET = 1'b0;
  logic              START = 1'b0;
  logic [ADDR_W-1:0] PC_CUR;
  logic              MEM_ACK = 1'b0;
  logic [2:0]        OPCODE = 3'b000;
  logic [ADDR_W-1:0] TARGET = '0;
  logic              ZERO = 1'b0;
  logic              FETCH_REQ;
  logic              IR_LOAD;
  logic [ADDR_W-1:0] PC_NEXT;
  logic              PC_LOAD;
  logic              HALTED;
  logic              STK_ERR;

  pc_sequencer #(.ADDR_W(ADDR_W), .STACK_DEPTH(2)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .START     (START),
    .PC_CUR    (PC_CUR),
    .MEM_ACK   (MEM_ACK),
    .OPCODE    (OPCODE),
    .TARGET    (TARGET),
    .ZERO      (ZERO),
    .FETCH_REQ (FETCH_REQ),
    .IR_LOAD   (IR_LOAD),
    .PC_NEXT   (PC_NEXT),
    .PC_LOAD   (PC_LOAD),
    .HALTED    (HALTED),
    .STK_ERR   (STK_ERR)
  );

  always #5 CLK = ~CLK;

  // PC register fed by the sequencer.
  always @(posedge CLK or posedge RESET) begin
    if (RESET) PC_CUR <= '0;
    else if (PC_LOAD) PC_CUR <= PC_NEXT;
  end

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  logic [2:0]        mem_op [4];
  logic [ADDR_W-1:0] mem_tg [4];
  logic [ADDR_W-1:0] exp_q [$];

  int n_total = 0;
  int n_bad = 0;
  int ack_delay = 0;
  int wait_cnt = 0;
  int ld_cnt = 0;
  int ir_cnt = 0;
  int fr_total = 0;
  int fr_run = 0;
  int last_fr_run = 0;
  int ld_at_ir = 0;
  int prev_ld_cyc = 0;
  bit have_prev = 1'b0;
  bit gap_chk = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Monitor, scoreboard and memory responder, all on the falling edge.
  initial begin
    forever begin
      @(negedge CLK);
      if (FETCH_REQ) begin
        fr_run++;
        fr_total++;
      end else if (fr_run != 0) begin
        last_fr_run = fr_run;
        fr_run = 0;
      end
      if (PC_LOAD) begin
        check("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("pc_next", 32'(PC_NEXT), 32'(exp_q.pop_front()));
        if (gap_chk && have_prev) check("load_gap", 32'(cyc - prev_ld_cyc), 32'd3);
        prev_ld_cyc = cyc;
        have_prev = 1'b1;
        ld_cnt++;
      end
      if (FETCH_REQ && wait_cnt == ack_delay) begin
        MEM_ACK = 1'b1;
        OPCODE = mem_op[PC_CUR];
        TARGET = mem_tg[PC_CUR];
      end else begin
        MEM_ACK = 1'b0;
      end
      wait_cnt = FETCH_REQ ? wait_cnt + 1 : 0;
      #1;
      if (IR_LOAD) begin
        ir_cnt++;
        ld_at_ir = ld_cnt;
      end
    end
  end

  task automatic do_reset();
    @(negedge CLK); #2;
    RESET = 1'b1;
    START = 1'b0;
    exp_q.delete();
    ld_cnt = 0; ir_cnt = 0; fr_total = 0; fr_run = 0; last_fr_run = 0;
    have_prev = 1'b0; gap_chk = 1'b0; ack_delay = 0;
    repeat (2) @(negedge CLK);
    #2;
    RESET = 1'b0;
  endtask

  task automatic fill(input logic [2:0] op);
    for (int i = 0; i < 4; i++) begin
      mem_op[i] = op;
      mem_tg[i] = '0;
    end
  endtask

  task automatic set_mem(input int a, input logic [2:0] op, input logic [ADDR_W-1:0] tg);
    mem_op[a] = op;
    mem_tg[a] = tg;
  endtask

  task automatic push(input int v);
    exp_q.push_back(ADDR_W'(v));
  endtask

  task automatic start_pulse();
    START = 1'b1;
    @(negedge CLK); #2;
    START = 1'b0;
  endtask

  task automatic wait_loads(input int n, input int budget);
    int k = 0;
    while (ld_cnt < n && k < budget) begin
      @(negedge CLK); #2;
      k++;
    end
    check("loads_seen", 32'(ld_cnt), 32'(n));
  endtask

  task automatic run(input int n);
    start_pulse();
    wait_loads(n, 200);
    @(negedge CLK); #2;
  endtask

  // One decided instruction at address 0, HLT everywhere else.
  task automatic run_case(input string tag, input logic [2:0] op0, input logic [ADDR_W-1:0] tg0,
                          input logic z, input int e0, input int e1);
    do_reset();
    fill(OP_HLT);
    set_mem(0, op0, tg0);
    ZERO = z;
    push(e0);
    push(e1);
    run(2);
    check({tag, "_halted"}, 32'(HALTED), 32'd1);
    check({tag, "_pc"}, 32'(PC_CUR), 32'(e1));
    check({tag, "_stk_err"}, 32'(STK_ERR), 32'd0);
  endtask

  initial begin
    #100000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s_ld;
    int s_fr;
    fill(OP_NOP);

    // Reset state.
    do_reset();
    check("rst_fetch_req", 32'(FETCH_REQ), 32'd0);
    check("rst_ir_load", 32'(IR_LOAD), 32'd0);
    check("rst_pc_load", 32'(PC_LOAD), 32'd0);
    check("rst_halted", 32'(HALTED), 32'd0);
    check("rst_stk_err", 32'(STK_ERR), 32'd0);
    check("rst_pc_next", 32'(PC_NEXT), 32'd0);

    // NOP stream with immediate ack: load every 3rd cycle, PC wraps 3 -> 0.
    do_reset();
    fill(OP_NOP);
    gap_chk = 1'b1;
    push(1); push(2); push(3); push(0);
    start_pulse();
    wait_loads(4, 100);
    check("nop_ir_pulses", 32'(ir_cnt), 32'd4);
    check("nop_fetch_len", 32'(last_fr_run), 32'd1);
    gap_chk = 1'b0;
    @(negedge CLK); #2;
    check("midfetch_req_before", 32'(FETCH_REQ), 32'd1);
    RESET = 1'b1;
    #1;
    check("midfetch_req", 32'(FETCH_REQ), 32'd0);
    check("midfetch_ir", 32'(IR_LOAD), 32'd0);
    check("midfetch_pc_next", 32'(PC_NEXT), 32'd0);
    check("midfetch_pc_load", 32'(PC_LOAD), 32'd0);
    @(negedge CLK); #2;
    RESET = 1'b0;
    s_ld = ld_cnt;
    s_fr = fr_total;
    repeat (10) @(negedge CLK);
    #2;
    check("idle_no_load", 32'(ld_cnt), 32'(s_ld));
    check("idle_no_fetch", 32'(fr_total), 32'(s_fr));

    // Delayed ack, then HLT at PC=1 and resume.
    do_reset();
    fill(OP_NOP);
    set_mem(1, OP_HLT, 0);
    ack_delay = 4;
    push(1); push(2);
    start_pulse();
    wait_loads(1, 100);
    check("delay_fetch_len", 32'(last_fr_run), 32'd5);
    check("delay_ir_pulses", 32'(ir_cnt), 32'd1);
    check("delay_no_early_load", 32'(ld_at_ir), 32'd0);
    wait_loads(2, 100);
    @(negedge CLK); #2;
    check("hlt_halted", 32'(HALTED), 32'd1);
    check("hlt_pc", 32'(PC_CUR), 32'd2);
    s_fr = fr_total;
    repeat (10) @(negedge CLK);
    #2;
    check("hlt_no_fetch", 32'(fr_total), 32'(s_fr));
    check("hlt_still_halted", 32'(HALTED), 32'd1);
    ack_delay = 0;
    push(3);
    start_pulse();
    wait_loads(3, 100);
    check("resume_not_halted", 32'(HALTED), 32'd0);

    // Branches, jump and reserved opcode.
    run_case("brz_z1", OP_BRZ, 2, 1'b1, 2, 3);
    run_case("brz_z0", OP_BRZ, 2, 1'b0, 1, 2);
    run_case("brnz_z1", OP_BRNZ, 2, 1'b1, 1, 2);
    run_case("brnz_z0", OP_BRNZ, 2, 1'b0, 2, 3);
    run_case("jmp3", OP_JMP, 3, 1'b0, 3, 0);
    run_case("rsv", OP_RSV, 3, 1'b0, 1, 2);

`ifdef SEQ_STACK_EN
    // CALL 3 then RET back to 1, HLT there.
    do_reset();
    fill(OP_HLT);
    set_mem(0, OP_CALL, 3);
    set_mem(3, OP_RET, 0);
    push(3); push(1); push(2);
    run(3);
    check("callret_pc", 32'(PC_CUR), 32'd2);
    check("callret_stk_err", 32'(STK_ERR), 32'd0);

    // Three nested CALLs overflow a 2-deep stack; jump still taken.
    do_reset();
    fill(OP_HLT);
    set_mem(0, OP_CALL, 1);
    set_mem(1, OP_CALL, 2);
    set_mem(2, OP_CALL, 3);
    push(1); push(2); push(3); push(0);
    run(4);
    check("ovf_pc", 32'(PC_CUR), 32'd0);
    check("ovf_stk_err", 32'(STK_ERR), 32'd1);

    // RET on empty stack at PC=2 steps to 3.
    do_reset();
    fill(OP_HLT);
    set_mem(0, OP_JMP, 2);
    set_mem(2, OP_RET, 0);
    push(2); push(3); push(0);
    run(3);
    check("unf_pc", 32'(PC_CUR), 32'd0);
    check("unf_stk_err", 32'(STK_ERR), 32'd1);
`else
    // CALL acts as JMP, RET as NOP; no error flag.
    do_reset();
    fill(OP_HLT);
    set_mem(0, OP_CALL, 3);
    set_mem(3, OP_RET, 0);
    push(3); push(0);
    run(2);
    check("nostk_pc", 32'(PC_CUR), 32'd0);
    check("nostk_stk_err", 32'(STK_ERR), 32'd0);
    run_case("nostk_ret", OP_RET, 3, 1'b0, 1, 2);
`endif

    // Reset during EXEC, then no activity until START.
    do_reset();
    fill(OP_NOP);
    push(1);
    start_pulse();
    wait_loads(1, 100);
    check("midexec_pc_load_before", 32'(PC_LOAD), 32'd1);
    RESET = 1'b1;
    #1;
    check("midexec_pc_load", 32'(PC_LOAD), 32'd0);
    check("midexec_pc_next", 32'(PC_NEXT), 32'd0);
    check("midexec_fetch_req", 32'(FETCH_REQ), 32'd0);
    check("midexec_halted", 32'(HALTED), 32'd0);
    @(negedge CLK); #2;
    RESET = 1'b0;
    s_ld = ld_cnt;
    s_fr = fr_total;
    repeat (10) @(negedge CLK);
    #2;
    check("postrst_no_load", 32'(ld_cnt), 32'(s_ld));
    check("postrst_no_fetch", 32'(fr_total), 32'(s_fr));
    push(1);
    start_pulse();
    wait_loads(s_ld + 1, 100);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
